// File: rtl/ram_ctrl_pkg.sv
// Shared width defaults and FSM state encoding for the RAM port arbiter.
package ram_ctrl_pkg;
    localparam int RAM_ADDR_W = 10;
    localparam int RAM_DATA_W = 8;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;
endpackage

// File: rtl/ram_3.sv
// Behavioural model of the shared 1K x 8 RAM: synchronous write, combinational read.
module ram_3 #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr,
    input  logic          cs,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (cs && wr) mem[addr] <= data_in;
    end

    assign data_out = mem[addr];
endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arb2
    import ram_ctrl_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic valid,
    output logic winner
);
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ~last_grant : req1;
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for a single RAM: grants one command at a time,
// holds the RAM strobes for 1+WAIT_STATES cycles and pulses a per-port done.
module ram_port_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              wr0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_wr,
    output logic              ram_cs,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              cs_q, cs_d, wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              arb_valid, arb_winner;

    rr_arb2 u_arb (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_q),
        .valid      (arb_valid),
        .winner     (arb_winner)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        cs_d    = cs_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_INIT;
                    last_d  = arb_winner;
                    gnt0_d  = ~arb_winner;
                    gnt1_d  = arb_winner;
                    cs_d    = 1'b1;
                    wr_d    = arb_winner ? wr1    : wr0;
                    addr_d  = arb_winner ? addr1  : addr0;
                    din_d   = arb_winner ? wdata1 : wdata0;
                end
            end
            ACCESS: begin
                // The owner is recovered from the grant flops when issuing done.
                if (cnt_q == '0) begin
                    if (!wr_q) rdata_d = ram_dout;
                    state_d = DONE;
                    cs_d    = 1'b0;
                    wr_d    = 1'b0;
                    gnt0_d  = 1'b0;
                    gnt1_d  = 1'b0;
                    done0_d = gnt0_q;
                    done1_d = gnt1_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rdata_q <= rdata_d;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign done0    = done0_q;
    assign done1    = done1_q;
    assign ram_cs   = cs_q;
    assign ram_wr   = wr_q;
    assign ram_addr = addr_q;
    assign ram_din  = din_q;
    assign rdata    = rdata_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: one instance with no wait states, one with two,
// each driving its own RAM model, checked against a transaction-level reference.
module tb_ram_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_s [2], wr0_s [2], req1_s [2], wr1_s [2];
    logic [9:0] addr0_s [2], addr1_s [2];
    logic [7:0] wdata0_s [2], wdata1_s [2];
    logic       gnt0_s [2], gnt1_s [2], done0_s [2], done1_s [2];
    logic [7:0] rdata_s [2], ram_din_s [2], ram_dout_s [2];
    logic [9:0] ram_addr_s [2];
    logic       ram_wr_s [2], ram_cs_s [2];

    for (genvar g = 0; g < 2; g++) begin : g_inst
        ram_port_arbiter #(.ADDR_W(10), .DATA_W(8), .WAIT_STATES(2 * g)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0_s[g]), .wr0(wr0_s[g]), .addr0(addr0_s[g]), .wdata0(wdata0_s[g]),
            .gnt0(gnt0_s[g]), .done0(done0_s[g]),
            .req1(req1_s[g]), .wr1(wr1_s[g]), .addr1(addr1_s[g]), .wdata1(wdata1_s[g]),
            .gnt1(gnt1_s[g]), .done1(done1_s[g]),
            .rdata(rdata_s[g]), .ram_addr(ram_addr_s[g]), .ram_din(ram_din_s[g]),
            .ram_wr(ram_wr_s[g]), .ram_cs(ram_cs_s[g]), .ram_dout(ram_dout_s[g])
        );
        ram_3 #(.AW(10), .DW(8)) ram (
            .clk(clk), .addr(ram_addr_s[g]), .wr(ram_wr_s[g]), .cs(ram_cs_s[g]),
            .data_in(ram_din_s[g]), .data_out(ram_dout_s[g])
        );
    end

    int checks = 0;
    int errors = 0;

    // Reference model: last winner, expected rdata, memory image and each port's pending command.
    logic       last_g [2];
    logic [7:0] exp_rdata [2];
    logic [7:0] model_mem [2][1024];
    logic       pend_req [2][2], pend_wr [2][2];
    logic [9:0] pend_addr [2][2];
    logic [7:0] pend_data [2][2];
    logic [9:0] pool [8] = '{10'd32, 10'd64, 10'd128, 10'd256, 10'd512, 10'd5, 10'd777, 10'd1023};

    function automatic int wsOf(input int k);
        return 2 * k;
    endfunction

    function automatic logic getGnt(input int k, input int p);
        return (p == 0) ? gnt0_s[k] : gnt1_s[k];
    endfunction

    function automatic logic getDone(input int k, input int p);
        return (p == 0) ? done0_s[k] : done1_s[k];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int k, input int p, input logic r, input logic w,
                                 input logic [9:0] a, input logic [7:0] d);
        pend_req[k][p]  = r;
        pend_wr[k][p]   = w;
        pend_addr[k][p] = a;
        pend_data[k][p] = d;
        if (p == 0) begin
            req0_s[k] = r; wr0_s[k] = w; addr0_s[k] = a; wdata0_s[k] = d;
        end else begin
            req1_s[k] = r; wr1_s[k] = w; addr1_s[k] = a; wdata1_s[k] = d;
        end
    endtask

    task automatic raiseRandom(input int k, input int p);
        applyStimulus(k, p, 1'b1, 1'($urandom_range(1, 0)), pool[$urandom_range(7, 0)], 8'($urandom));
    endtask

    task automatic checkIdle(input int k, input string tag);
        checkOutput($sformatf("k%0d_%s_gnt0", k, tag), gnt0_s[k], 0);
        checkOutput($sformatf("k%0d_%s_gnt1", k, tag), gnt1_s[k], 0);
        checkOutput($sformatf("k%0d_%s_done0", k, tag), done0_s[k], 0);
        checkOutput($sformatf("k%0d_%s_done1", k, tag), done1_s[k], 0);
        checkOutput($sformatf("k%0d_%s_cs", k, tag), ram_cs_s[k], 0);
        checkOutput($sformatf("k%0d_%s_wr", k, tag), ram_wr_s[k], 0);
        checkOutput($sformatf("k%0d_%s_rdata", k, tag), rdata_s[k], exp_rdata[k]);
    endtask

    task automatic checkReset(input int k);
        checkIdle(k, "rst");
        checkOutput($sformatf("k%0d_rst_addr", k), ram_addr_s[k], 0);
        checkOutput($sformatf("k%0d_rst_din", k), ram_din_s[k], 0);
    endtask

    // Serve one command starting from an IDLE cycle: grant edge, ACCESS cycles, DONE, IDLE.
    task automatic serviceOne(input int k, input bit scramble, input bit drop_mid, output int obs_win);
        int         w;
        logic       cw;
        logic [9:0] ca;
        logic [7:0] cd;
        w  = (pend_req[k][0] && pend_req[k][1]) ? (last_g[k] ? 0 : 1) : (pend_req[k][1] ? 1 : 0);
        cw = pend_wr[k][w];
        ca = pend_addr[k][w];
        cd = pend_data[k][w];
        obs_win = -1;
        @(posedge clk);
        last_g[k] = w[0];
        for (int i = 0; i <= wsOf(k); i++) begin
            @(negedge clk);
            if (i == 0) obs_win = gnt1_s[k] ? 1 : (gnt0_s[k] ? 0 : -1);
            checkOutput($sformatf("k%0d_acc_gnt_win", k), getGnt(k, w), 1);
            checkOutput($sformatf("k%0d_acc_gnt_other", k), getGnt(k, 1 - w), 0);
            checkOutput($sformatf("k%0d_acc_cs", k), ram_cs_s[k], 1);
            checkOutput($sformatf("k%0d_acc_wr", k), ram_wr_s[k], cw);
            checkOutput($sformatf("k%0d_acc_addr", k), ram_addr_s[k], ca);
            checkOutput($sformatf("k%0d_acc_din", k), ram_din_s[k], cd);
            checkOutput($sformatf("k%0d_acc_done0", k), done0_s[k], 0);
            checkOutput($sformatf("k%0d_acc_done1", k), done1_s[k], 0);
            checkOutput($sformatf("k%0d_acc_rdata", k), rdata_s[k], exp_rdata[k]);
            if (i == 0 && (scramble || drop_mid))
                applyStimulus(k, w, drop_mid ? 1'b0 : 1'b1,
                              scramble ? 1'($urandom_range(1, 0)) : cw,
                              scramble ? 10'($urandom) : ca,
                              scramble ? 8'($urandom) : cd);
        end
        @(negedge clk);
        if (cw) model_mem[k][ca] = cd;
        else    exp_rdata[k] = model_mem[k][ca];
        checkOutput($sformatf("k%0d_done_win", k), getDone(k, w), 1);
        checkOutput($sformatf("k%0d_done_other", k), getDone(k, 1 - w), 0);
        checkOutput($sformatf("k%0d_done_gnt0", k), gnt0_s[k], 0);
        checkOutput($sformatf("k%0d_done_gnt1", k), gnt1_s[k], 0);
        checkOutput($sformatf("k%0d_done_cs", k), ram_cs_s[k], 0);
        checkOutput($sformatf("k%0d_done_wr", k), ram_wr_s[k], 0);
        checkOutput($sformatf("k%0d_done_rdata", k), rdata_s[k], exp_rdata[k]);
        applyStimulus(k, w, 1'b0, pend_wr[k][w], pend_addr[k][w], pend_data[k][w]);
        @(negedge clk);
        checkIdle(k, "after_done");
    endtask

    task automatic runDirected(input int k);
        int         ow;
        logic [9:0] seq_addr [4];
        logic [7:0] seq_data [4];
        seq_addr = '{10'd64, 10'd128, 10'd256, 10'd512};
        seq_data = '{8'hAC, 8'h9B, 8'h8F, 8'h7F};

        applyStimulus(k, 0, 1'b1, 1'b1, 10'd32, 8'hFF);
        serviceOne(k, 1'b0, 1'b0, ow);
        applyStimulus(k, 0, 1'b1, 1'b0, 10'd32, 8'h00);
        serviceOne(k, 1'b0, 1'b0, ow);
        checkOutput($sformatf("k%0d_read32", k), rdata_s[k], 8'hFF);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(k, 0, 1'b1, 1'b1, seq_addr[i], seq_data[i]);
            serviceOne(k, 1'b0, 1'b0, ow);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(k, 1, 1'b1, 1'b0, seq_addr[i], 8'h00);
            serviceOne(k, 1'b0, 1'b0, ow);
            checkOutput($sformatf("k%0d_p1_owner", k), ow, 1);
            checkOutput($sformatf("k%0d_read_seq%0d", k, i), rdata_s[k], seq_data[i]);
        end

        for (int i = 0; i < 8; i++) begin
            applyStimulus(k, 0, 1'b1, 1'b1, pool[i], 8'($urandom));
            serviceOne(k, 1'b0, 1'b0, ow);
        end

        // Last winner was port 0 here, so a tie must start with port 1... unless reset
        // semantics; the model decides, while the alternation itself is checked explicitly.
        raiseRandom(k, 0);
        raiseRandom(k, 1);
        for (int i = 0; i < 4; i++) begin
            serviceOne(k, 1'b0, 1'b0, ow);
            checkOutput($sformatf("k%0d_rr_seq%0d", k, i), ow, (i % 2 == 0) ? 1 : 0);
            if (i < 2) begin
                for (int p = 0; p < 2; p++) if (!pend_req[k][p]) raiseRandom(k, p);
            end
        end

        applyStimulus(k, 1, 1'b1, 1'b1, pool[$urandom_range(7, 0)], 8'($urandom));
        serviceOne(k, 1'b0, 1'b1, ow);
        checkOutput($sformatf("k%0d_drop_owner", k), ow, 1);
        repeat (4) begin
            @(negedge clk);
            checkIdle(k, "stay_idle");
        end
    endtask

    task automatic runRandom(input int k);
        int ow;
        int mask;
        int nserv;
        for (int n = 0; n < 30; n++) begin
            mask  = $urandom_range(3, 1);
            nserv = 0;
            for (int p = 0; p < 2; p++) begin
                if (mask[p]) begin
                    raiseRandom(k, p);
                    nserv++;
                end
            end
            for (int j = 0; j < nserv; j++)
                serviceOne(k, 1'($urandom_range(1, 0)), $urandom_range(3, 0) == 0, ow);
            if ($urandom_range(3, 0) == 0) begin
                @(negedge clk);
                checkIdle(k, "gap");
            end
        end
    endtask

    task automatic runResetMidOp(input int k);
        int ow;
        applyStimulus(k, 0, 1'b1, 1'b1, 10'd64, 8'h55);
        @(posedge clk);
        @(negedge clk);
        checkOutput($sformatf("k%0d_rst_in_access", k), gnt0_s[k], 1);
        rst_n = 1'b0;
        applyStimulus(k, 0, 1'b0, 1'b0, 10'd0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        for (int kk = 0; kk < 2; kk++) begin
            last_g[kk]    = 1'b1;
            exp_rdata[kk] = 8'h00;
            checkReset(kk);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkIdle(k, "no_done_after_rst");
        applyStimulus(k, 0, 1'b1, 1'b0, 10'd128, 8'h00);
        applyStimulus(k, 1, 1'b1, 1'b0, 10'd256, 8'h00);
        serviceOne(k, 1'b0, 1'b0, ow);
        checkOutput($sformatf("k%0d_post_rst_first", k), ow, 0);
        serviceOne(k, 1'b0, 1'b0, ow);
        checkOutput($sformatf("k%0d_post_rst_second", k), ow, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 2; p++) applyStimulus(k, p, 1'b0, 1'b0, 10'd0, 8'h00);
            last_g[k]    = 1'b1;
            exp_rdata[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) checkReset(k);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) checkIdle(k, "post_reset");

        for (int k = 0; k < 2; k++) runDirected(k);
        for (int k = 0; k < 2; k++) runRandom(k);
        for (int k = 0; k < 2; k++) runResetMidOp(k);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
